// File: rtl/disp_pkg.sv
// Shared constants for the memory-mapped seven-segment display peripheral:
// register offsets, CTRL bit layout and the active-low hex segment table.
package disp_pkg;

   localparam logic [31:0] DATA_OFFSET = 32'd0;
   localparam logic [31:0] CTRL_OFFSET = 32'd4;
   localparam int          CTRL_EN_BIT = 0;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Entry n is the active-low {g,f,e,d,c,b,a} pattern for hex digit n.
   localparam logic [15:0][6:0] SEG_CODES = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/mmio_display_ctrl_if.sv
// Data-memory bus slice seen by the display peripheral: the CPU is the master,
// the peripheral answers reads one cycle later.
interface mmio_display_ctrl_if;

   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wen;
   logic [3:0]  be;
   logic        ren;
   logic [31:0] rdata;
   logic        rvalid;

   modport master (
      output addr, wdata, wen, be, ren,
      input  rdata, rvalid
   );

   modport slave (
      input  addr, wdata, wen, be, ren,
      output rdata, rvalid
   );

endinterface

// File: rtl/seg7_encode.sv
// Nibble to active-low seven-segment code, with a blank override.
module seg7_encode
   import disp_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg_n
);

   assign seg_n = blank ? SEG_BLANK : SEG_CODES[nibble];

endmodule

// File: rtl/mmio_display_ctrl.sv
// Seven-segment display peripheral: DATA/CTRL registers, per-digit static outputs
// and a common-anode scan. Define DISP_LZ_BLANK_EN to compile in leading-zero blanking.
module mmio_display_ctrl
   import disp_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0064,
   parameter logic [31:0] ALIAS_ADDR = 32'h8000_0000,
   parameter int          N_DIGITS   = 8,
   parameter int          SCAN_DIV   = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mmio_display_ctrl_if.slave    bus,
   output logic [6:0]            seg_n,
   output logic [N_DIGITS-1:0]   dig_n,
   output logic [N_DIGITS*7-1:0] seg_static
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   logic [31:0]         data_q;
   logic                ctrl_en;
   logic [CNT_W-1:0]    scan_cnt;
   logic [IDX_W-1:0]    scan_idx;
   logic [N_DIGITS-1:0] digit_blank;
   logic                data_hit;
   logic                ctrl_hit;

   assign data_hit = (bus.addr == BASE_ADDR + DATA_OFFSET) || (bus.addr == ALIAS_ADDR);
   assign ctrl_hit = (bus.addr == BASE_ADDR + CTRL_OFFSET);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         ctrl_en <= 1'b1;
      end else if (bus.wen) begin
         if (data_hit) begin
            for (int k = 0; k < 4; k++) begin
               if (bus.be[k]) data_q[8*k +: 8] <= bus.wdata[8*k +: 8];
            end
         end
         if (ctrl_hit && bus.be[0]) ctrl_en <= bus.wdata[CTRL_EN_BIT];
      end
   end

   // Reads sample the registers before any same-cycle write lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rdata  <= '0;
         bus.rvalid <= 1'b0;
      end else begin
         bus.rvalid <= bus.ren;
         if (bus.ren) begin
            if (data_hit)      bus.rdata <= data_q;
            else if (ctrl_hit) bus.rdata <= 32'(ctrl_en) << CTRL_EN_BIT;
            else               bus.rdata <= '0;
         end
      end
   end

   // While disabled the scan parks on digit 0 so re-enabling starts a fresh period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (!ctrl_en) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         scan_idx <= (scan_idx == IDX_W'(N_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
`ifdef DISP_LZ_BLANK_EN
      if (g == 0) begin : g_first
         assign digit_blank[g] = !ctrl_en;
      end else begin : g_upper
         assign digit_blank[g] = !ctrl_en || (data_q[4*N_DIGITS-1:4*g] == '0);
      end
`else
      assign digit_blank[g] = !ctrl_en;
`endif
      seg7_encode u_enc (
         .nibble (data_q[4*g +: 4]),
         .blank  (digit_blank[g]),
         .seg_n  (seg_static[7*g +: 7])
      );
   end

   always_comb begin
      seg_n = SEG_BLANK;
      dig_n = '1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (int'(scan_idx) == i) begin
            seg_n = seg_static[7*i +: 7];
            if (ctrl_en) dig_n[i] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mmio_display_ctrl.sv
// Self-checking bench for mmio_display_ctrl: an 8-digit and a 3-digit instance share
// one bus stimulus and are checked against a register/scan model kept in the bench.
module tb_mmio_display_ctrl;

   localparam logic [31:0] BASE  = 32'h8000_0064;
   localparam logic [31:0] ALIAS = 32'h8000_0000;
   localparam logic [31:0] CTRL  = 32'h8000_0068;
   localparam int          SDIV  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   mmio_display_ctrl_if bus ();
   mmio_display_ctrl_if bus3 ();

   logic [6:0]  seg_n8, seg_n3;
   logic [7:0]  dig_n8;
   logic [2:0]  dig_n3;
   logic [55:0] stat8;
   logic [20:0] stat3;

   assign bus3.addr  = bus.addr;
   assign bus3.wdata = bus.wdata;
   assign bus3.wen   = bus.wen;
   assign bus3.be    = bus.be;
   assign bus3.ren   = bus.ren;

   mmio_display_ctrl #(.N_DIGITS(8), .SCAN_DIV(SDIV)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .seg_n(seg_n8), .dig_n(dig_n8), .seg_static(stat8)
   );

   mmio_display_ctrl #(.N_DIGITS(3), .SCAN_DIV(SDIV)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3),
      .seg_n(seg_n3), .dig_n(dig_n3), .seg_static(stat3)
   );

   always #5 clk = ~clk;

   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic [31:0] m_data;
   logic        m_en;
   int          ticks;
   logic [31:0] exp_rdata;
   logic        exp_rvalid;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [6:0] exp_digit(input logic [31:0] d, input int n, input int i);
      logic [3:0] nib;
`ifdef DISP_LZ_BLANK_EN
      logic [63:0] shown;
      shown = {32'd0, d} & ((64'd1 << (4*n)) - 64'd1);
      if (m_en && i > 0 && (shown >> (4*i)) == 64'd0) return 7'h7F;
`endif
      if (!m_en) return 7'h7F;
      nib = 4'(d >> (4*i));
      return hex_tab[nib];
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a);
      if (a == BASE || a == ALIAS) return m_data;
      if (a == CTRL) return {31'd0, m_en};
      return 32'd0;
   endfunction

   function automatic int exp_idx(input int n);
      return (ticks / SDIV) % n;
   endfunction

   function automatic logic [7:0] exp_dig8();
      return m_en ? ~(8'd1 << exp_idx(8)) : 8'hFF;
   endfunction

   function automatic logic [2:0] exp_dig3();
      return m_en ? ~(3'd1 << exp_idx(3)) : 3'b111;
   endfunction

   // One clock edge: the model absorbs the bus inputs currently driven.
   task automatic cycle();
      logic        en_before;
      logic [31:0] mask;
      en_before  = m_en;
      exp_rvalid = bus.ren;
      if (bus.ren) exp_rdata = exp_read(bus.addr);
      if (bus.wen) begin
         mask = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
         if (bus.addr == BASE || bus.addr == ALIAS) m_data = (m_data & ~mask) | (bus.wdata & mask);
         else if (bus.addr == CTRL && bus.be[0]) m_en = bus.wdata[0];
      end
      ticks = en_before ? ticks + 1 : 0;
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_data     = 32'd0;
      m_en       = 1'b1;
      ticks      = 0;
      exp_rdata  = 32'd0;
      exp_rvalid = 1'b0;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                        input logic w, input logic r);
      bus.addr  = a;
      bus.wdata = d;
      bus.be    = b;
      bus.wen   = w;
      bus.ren   = r;
   endtask

   task automatic idle();
      bus.wen = 1'b0;
      bus.ren = 1'b0;
   endtask

   task automatic test_reset();
      drive(32'd0, 32'd0, 4'h0, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      checks++; if (bus.rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset rdata: got %h expected 0", bus.rdata); end
      checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset rvalid: got %b expected 0", bus.rvalid); end
      checks++; if (dig_n8 !== 8'hFE) begin errors++; $display("[TB] FAIL reset dig_n8: got %h expected fe", dig_n8); end
      checks++; if (dig_n3 !== 3'b110) begin errors++; $display("[TB] FAIL reset dig_n3: got %b expected 110", dig_n3); end
      checks++; if (seg_n8 !== 7'h40) begin errors++; $display("[TB] FAIL reset seg_n8: got %h expected 40", seg_n8); end
      checks++; if (seg_n3 !== 7'h40) begin errors++; $display("[TB] FAIL reset seg_n3: got %h expected 40", seg_n3); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (stat8[7*i +: 7] !== exp_digit(m_data, 8, i)) begin
            errors++; $display("[TB] FAIL reset static8 digit %0d: got %h expected %h", i, stat8[7*i +: 7], exp_digit(m_data, 8, i));
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      logic [6:0] want [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
      drive(BASE, 32'h1234_ABCD, 4'hF, 1'b1, 1'b0);
      cycle(); idle();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (stat8[7*i +: 7] !== want[i]) begin
            errors++; $display("[TB] FAIL write static8 digit %0d: got %h expected %h", i, stat8[7*i +: 7], want[i]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (stat3[7*i +: 7] !== exp_digit(m_data, 3, i)) begin
            errors++; $display("[TB] FAIL write static3 digit %0d: got %h expected %h", i, stat3[7*i +: 7], exp_digit(m_data, 3, i));
         end
      end
      drive(BASE, 32'd0, 4'h0, 1'b0, 1'b1);
      cycle(); idle();
      checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("[TB] FAIL read rvalid: got %b expected 1", bus.rvalid); end
      checks++; if (bus.rdata !== 32'h1234_ABCD) begin errors++; $display("[TB] FAIL read rdata: got %h expected 1234abcd", bus.rdata); end
      checks++; if (bus3.rdata !== 32'h1234_ABCD) begin errors++; $display("[TB] FAIL read rdata3: got %h expected 1234abcd", bus3.rdata); end
      cycle();
      checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL read rvalid drop: got %b expected 0", bus.rvalid); end
      checks++; if (bus.rdata !== 32'h1234_ABCD) begin errors++; $display("[TB] FAIL read rdata hold: got %h expected 1234abcd", bus.rdata); end
   endtask

   task automatic test_byte_enable();
      drive(BASE, 32'd0, 4'hF, 1'b1, 1'b0);
      cycle();
      drive(ALIAS, 32'hFFFF_FFFF, 4'b0010, 1'b1, 1'b0);
      cycle();
      drive(ALIAS, 32'd0, 4'h0, 1'b0, 1'b1);
      cycle(); idle();
      checks++; if (bus.rdata !== 32'h0000_FF00) begin errors++; $display("[TB] FAIL byte enable rdata: got %h expected 0000ff00", bus.rdata); end
      drive(CTRL, 32'd0, 4'b1110, 1'b1, 1'b0);
      cycle();
      drive(CTRL, 32'd0, 4'h0, 1'b0, 1'b1);
      cycle();
      drive(32'h8000_0070, 32'd0, 4'h0, 1'b0, 1'b1);
      checks++; if (bus.rdata !== 32'd1) begin errors++; $display("[TB] FAIL ctrl be0 ignored: got %h expected 1", bus.rdata); end
      cycle(); idle();
      checks++; if (bus.rdata !== 32'd0 || bus.rvalid !== 1'b1) begin errors++; $display("[TB] FAIL unmapped read: got %h/%b expected 0/1", bus.rdata, bus.rvalid); end
   endtask

   task automatic test_scan();
      drive(CTRL, 32'd0, 4'h1, 1'b1, 1'b0);
      cycle(); idle();
      checks++; if (dig_n8 !== 8'hFF || dig_n3 !== 3'b111) begin errors++; $display("[TB] FAIL disable dig_n: got %h/%b expected ff/111", dig_n8, dig_n3); end
      checks++; if (stat8 !== {8{7'h7F}} || stat3 !== {3{7'h7F}}) begin errors++; $display("[TB] FAIL disable static: got %h/%h expected all 7f", stat8, stat3); end
      drive(CTRL, 32'd1, 4'h1, 1'b1, 1'b0);
      cycle(); idle();
      for (int c = 0; c < 24; c++) begin
         checks++;
         if (dig_n8 !== exp_dig8() || dig_n3 !== exp_dig3()) begin
            errors++; $display("[TB] FAIL scan dig_n c=%0d: got %h/%b expected %h/%b", c, dig_n8, dig_n3, exp_dig8(), exp_dig3());
         end
         checks++;
         if (seg_n8 !== exp_digit(m_data, 8, exp_idx(8)) || seg_n3 !== exp_digit(m_data, 3, exp_idx(3))) begin
            errors++; $display("[TB] FAIL scan seg_n c=%0d: got %h/%h expected %h/%h", c, seg_n8, seg_n3,
                               exp_digit(m_data, 8, exp_idx(8)), exp_digit(m_data, 3, exp_idx(3)));
         end
         if (c == 9) drive(BASE, $urandom, 4'hF, 1'b1, 1'b0);
         cycle(); idle();
      end
   endtask

   task automatic test_lz_blank();
      drive(BASE, 32'h0000_0050, 4'hF, 1'b1, 1'b0);
      cycle(); idle();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (stat8[7*i +: 7] !== exp_digit(m_data, 8, i)) begin
            errors++; $display("[TB] FAIL lz 50 digit %0d: got %h expected %h", i, stat8[7*i +: 7], exp_digit(m_data, 8, i));
         end
      end
      drive(BASE, 32'hFFFF_F000, 4'hF, 1'b1, 1'b0);
      cycle(); idle();
      checks++; if (stat3 !== {3{exp_digit(m_data, 3, 1)}}) begin errors++; $display("[TB] FAIL lz upper ignored: got %h expected %h", stat3, {3{exp_digit(m_data, 3, 1)}}); end
      drive(BASE, 32'd0, 4'hF, 1'b1, 1'b0);
      cycle(); idle();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (stat8[7*i +: 7] !== exp_digit(m_data, 8, i)) begin
            errors++; $display("[TB] FAIL lz zero digit %0d: got %h expected %h", i, stat8[7*i +: 7], exp_digit(m_data, 8, i));
         end
      end
   endtask

   task automatic test_same_cycle();
      drive(BASE, 32'hCAFE_0123, 4'hF, 1'b1, 1'b0);
      cycle();
      drive(BASE, 32'h5555_AAAA, 4'hF, 1'b1, 1'b1);
      cycle(); idle();
      checks++; if (bus.rdata !== 32'hCAFE_0123) begin errors++; $display("[TB] FAIL same cycle data: got %h expected cafe0123", bus.rdata); end
      drive(CTRL, 32'd0, 4'hF, 1'b1, 1'b1);
      cycle(); idle();
      checks++; if (bus.rdata !== 32'd1) begin errors++; $display("[TB] FAIL same cycle ctrl: got %h expected 1", bus.rdata); end
      drive(CTRL, 32'd1, 4'hF, 1'b1, 1'b0);
      cycle(); idle();
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 3))
            0:       a = BASE;
            1:       a = ALIAS;
            2:       a = CTRL;
            default: a = $urandom;
         endcase
         drive(a, $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
         cycle(); idle();
         checks++;
         if (bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata || bus3.rdata !== exp_rdata) begin
            errors++; $display("[TB] FAIL random read %0d: got %h/%b expected %h/%b", n, bus.rdata, bus.rvalid, exp_rdata, exp_rvalid);
         end
         checks++;
         if (dig_n8 !== exp_dig8() || dig_n3 !== exp_dig3()) begin
            errors++; $display("[TB] FAIL random dig_n %0d: got %h/%b expected %h/%b", n, dig_n8, dig_n3, exp_dig8(), exp_dig3());
         end
         if (m_en) begin
            checks++;
            if (seg_n8 !== exp_digit(m_data, 8, exp_idx(8)) || seg_n3 !== exp_digit(m_data, 3, exp_idx(3))) begin
               errors++; $display("[TB] FAIL random seg_n %0d: got %h/%h expected %h/%h", n, seg_n8, seg_n3,
                                  exp_digit(m_data, 8, exp_idx(8)), exp_digit(m_data, 3, exp_idx(3)));
            end
         end
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (stat8[7*i +: 7] !== exp_digit(m_data, 8, i)) begin
               errors++; $display("[TB] FAIL random static8 %0d digit %0d: got %h expected %h", n, i, stat8[7*i +: 7], exp_digit(m_data, 8, i));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(CTRL, 32'd1, 4'h1, 1'b1, 1'b0);
      cycle();
      drive(BASE, 32'h8765_4321, 4'hF, 1'b1, 1'b0);
      cycle(); idle();
      for (int i = 0; i < 6; i++) cycle();
      drive(BASE, 32'd0, 4'h0, 1'b0, 1'b1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (bus.rvalid !== 1'b0 || bus.rdata !== 32'd0) begin errors++; $display("[TB] FAIL mid reset read: got %h/%b expected 0/0", bus.rdata, bus.rvalid); end
      checks++; if (dig_n8 !== 8'hFE || dig_n3 !== 3'b110) begin errors++; $display("[TB] FAIL mid reset dig_n: got %h/%b expected fe/110", dig_n8, dig_n3); end
      checks++; if (stat8[6:0] !== 7'h40 || stat8[13:7] !== exp_digit(m_data, 8, 1)) begin errors++; $display("[TB] FAIL mid reset static: got %h expected 40/%h", stat8[13:0], exp_digit(m_data, 8, 1)); end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      drive(BASE, 32'd0, 4'h0, 1'b0, 1'b1);
      cycle(); idle();
      checks++; if (bus.rdata !== 32'd0 || bus.rvalid !== 1'b1) begin errors++; $display("[TB] FAIL post reset read: got %h/%b expected 0/1", bus.rdata, bus.rvalid); end
      checks++; if (dig_n8 !== exp_dig8()) begin errors++; $display("[TB] FAIL post reset dig_n: got %h expected %h", dig_n8, exp_dig8()); end
   endtask

   initial begin
      $display("[TB] starting mmio_display_ctrl bench");
      test_reset();
      test_write_read();
      test_byte_enable();
      test_scan();
      test_lz_blank();
      test_same_cycle();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
